// File: rtl/coin_change_dispenser.sv
// Change-return controller: pays out an amount as dime/nickel pulses, one coin per hopper ack.
// Dimes go first and nickels are the fallback; ends in a done pulse, or an err pulse with the remainder in owed.
module coin_change_dispenser #(
    parameter int AMT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             dime_empty,
    input  logic             nick_empty,
    input  logic             coin_ack,
    output logic             dime_out,
    output logic             nick_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] owed
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic ok;
        logic dime;
    } pick_t;

    state_t           state;
    logic             coin_sel;
    logic [TMR_W-1:0] timer;
    logic [AMT_W-1:0] owed_dec;
    logic             amount_bad;
    pick_t            pick_start;
    pick_t            pick_next;

    // Dime only if at least 10 is owed, nickel only if at least 5, so owed can never underflow.
    function automatic pick_t select_coin(input logic [AMT_W-1:0] v,
                                          input logic no_dime,
                                          input logic no_nick);
        pick_t p;
        p = '{ok: 1'b1, dime: 1'b0};
        if (v >= AMT_W'(10) && !no_dime)
            p.dime = 1'b1;
        else if (!(v >= AMT_W'(5) && !no_nick))
            p.ok = 1'b0;
        return p;
    endfunction

    assign amount_bad = (amount % AMT_W'(5)) != '0;
    assign owed_dec   = owed - (coin_sel ? AMT_W'(10) : AMT_W'(5));
    assign pick_start = select_coin(amount, dime_empty, nick_empty);
    assign pick_next  = select_coin(owed_dec, dime_empty, nick_empty);

    // NOTE: state registers use non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owed     <= '0;
            coin_sel <= 1'b0;
            timer    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (amount_bad) begin
                            owed  <= amount;
                            state <= ERR;
                        end else if (amount == '0) begin
                            state <= DONE;
                        end else begin
                            owed     <= amount;
                            coin_sel <= pick_start.dime;
                            state    <= pick_start.ok ? ISSUE : ERR;
                        end
                    end
                end
                ISSUE: begin
                    timer <= TMR_W'(TIMEOUT);
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // An ack on the final timer cycle still counts; it is tested before expiry.
                    if (coin_ack) begin
                        owed <= owed_dec;
                        if (owed_dec == '0) begin
                            state <= DONE;
                        end else begin
                            coin_sel <= pick_next.dime;
                            state    <= pick_next.ok ? ISSUE : ERR;
                        end
                    end else if (timer == TMR_W'(1)) begin
                        state <= ERR;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                DONE, ERR: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Moore outputs: decoded from registered state, no input reaches them combinationally.
    assign dime_out = (state == ISSUE) && coin_sel;
    assign nick_out = (state == ISSUE) && !coin_sel;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = (state == ERR);

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: a timestamp-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with hopper and ack noise.
module tb_coin_change_dispenser;
    localparam int AMT_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic             dime_empty = 1'b0;
    logic             nick_empty = 1'b0;
    logic             coin_ack;
    logic             dime_out;
    logic             nick_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] owed;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit checking = 1'b0;

    // Model: expected events as cycle timestamps (cycle n = interval after posedge n).
    bit m_busy  = 1'b0;
    bit m_dime  = 1'b0;
    int m_owed  = 0;
    int pulse_at = -1;
    int done_at  = -1;
    int err_at   = -1;
    int win_lo   = -1;
    int win_hi   = -1;

    // Observations for the directed scenarios.
    int n_dime, n_nick, n_done, n_err;
    int first_pulse_cyc, last_done_cyc, last_err_cyc;
    int t0;

    int ack_delay = 1;  // cycles from observed pulse to driven ack; 0 = never ack
    bit noise = 1'b0;

    coin_change_dispenser #(.AMT_W(AMT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .amount     (amount),
        .dime_empty (dime_empty),
        .nick_empty (nick_empty),
        .coin_ack   (coin_ack),
        .dime_out   (dime_out),
        .nick_out   (nick_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .owed       (owed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Selection rule from the datasheet, producing the next expected coin or error time.
    task automatic plan_coin(input int e);
        win_lo = -1;
        win_hi = -1;
        if (m_owed >= 10 && !dime_empty) m_dime = 1'b1;
        else if (m_owed >= 5 && !nick_empty) m_dime = 1'b0;
        else begin
            err_at = e;
            return;
        end
        pulse_at = e;
        win_lo   = e + 2;
        win_hi   = e + 1 + TIMEOUT;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = 1'b0; m_owed = 0;
            pulse_at = -1; done_at = -1; err_at = -1; win_lo = -1; win_hi = -1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                if (int'(amount) % 5 != 0) begin
                    m_owed = int'(amount);
                    err_at = cyc;
                end else if (amount == 0) begin
                    done_at = cyc;
                end else begin
                    m_owed = int'(amount);
                    plan_coin(cyc);
                end
            end
        end else if (done_at == cyc - 1 || err_at == cyc - 1) begin
            m_busy = 1'b0;
        end else if (cyc >= win_lo && cyc <= win_hi) begin
            if (coin_ack) begin
                m_owed -= m_dime ? 10 : 5;
                if (m_owed == 0) begin
                    done_at = cyc;
                    win_hi = -1;
                end else begin
                    plan_coin(cyc);
                end
            end else if (cyc == win_hi) begin
                err_at = cyc;
                win_hi = -1;
            end
        end
    end

    // Compare process: all outputs against the model once per cycle, away from the edge.
    initial forever begin
        @(negedge clk);
        if (checking) begin
            check("outputs",
                  32'({dime_out, nick_out, busy, done, err, owed}),
                  32'({pulse_at == cyc && m_dime, pulse_at == cyc && !m_dime, m_busy,
                       done_at == cyc, err_at == cyc, AMT_W'(m_owed)}));
            if ((dime_out || nick_out) && first_pulse_cyc < 0) first_pulse_cyc = cyc;
            if (done) last_done_cyc = cyc;
            if (err) last_err_cyc = cyc;
            n_dime += int'(dime_out);
            n_nick += int'(nick_out);
            n_done += int'(done);
            n_err  += int'(err);
        end
    end

    // Hopper model: acks ack_delay cycles after each observed pulse, plus optional random acks.
    initial begin
        int cnt;
        cnt = 0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            coin_ack = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) coin_ack = 1'b1;
            end
            if (rst) cnt = 0;
            else if ((dime_out || nick_out) && ack_delay > 0) cnt = ack_delay;
            if (noise && $urandom_range(0, 15) == 0) coin_ack = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        n_dime = 0; n_nick = 0; n_done = 0; n_err = 0;
        first_pulse_cyc = -1; last_done_cyc = -1; last_err_cyc = -1;
        t0 = cyc;
    endtask

    // Called at a negedge with the DUT idle; returns one negedge after busy drops.
    task automatic run_txn(input int amt, input bit hold, input bit kill_dime);
        int n;
        clear_obs();
        start  = 1'b1;
        amount = AMT_W'(amt);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!hold || done || err) start = 1'b0;
            if (hold) amount = AMT_W'(7);
            if (kill_dime && dime_out) dime_empty = 1'b1;
        end while (busy === 1'b1 && n < 3000);
        if (busy !== 1'b0) check("txn_budget", 32'(busy), 32'(0));
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int amt;
        clear_obs();
        repeat (2) @(negedge clk);
        checking = 1'b1;
        check("reset_outputs", 32'({dime_out, nick_out, busy, done, err, owed}), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // 25 cents, full hoppers, ack after one cycle: dime, dime, nickel, done 7 cycles after start.
        ack_delay = 1;
        run_txn(25, 1'b0, 1'b0);
        check("d25_dimes", n_dime, 2);
        check("d25_nickels", n_nick, 1);
        check("d25_done", n_done, 1);
        check("d25_err", n_err, 0);
        check("d25_first_pulse", first_pulse_cyc - t0, 1);
        check("d25_done_latency", last_done_cyc - t0, 7);
        check("d25_owed", 32'(owed), 32'(0));

        // Dime hopper empty: three nickels.
        dime_empty = 1'b1;
        run_txn(15, 1'b0, 1'b0);
        check("d15_dimes", n_dime, 0);
        check("d15_nickels", n_nick, 3);
        check("d15_done", n_done, 1);
        dime_empty = 1'b0;

        // Dime hopper empties while the first dime is outstanding.
        run_txn(20, 1'b0, 1'b1);
        check("d20_dimes", n_dime, 1);
        check("d20_nickels", n_nick, 2);
        check("d20_done", n_done, 1);
        dime_empty = 1'b0;

        // Amount not a multiple of 5.
        run_txn(7, 1'b0, 1'b0);
        check("a7_err_latency", last_err_cyc - t0, 1);
        check("a7_pulses", n_dime + n_nick, 0);
        check("a7_owed", 32'(owed), 32'(7));

        // No coin possible.
        dime_empty = 1'b1;
        nick_empty = 1'b1;
        run_txn(10, 1'b0, 1'b0);
        check("a10_err_latency", last_err_cyc - t0, 1);
        check("a10_pulses", n_dime + n_nick, 0);
        check("a10_owed", 32'(owed), 32'(10));
        dime_empty = 1'b0;
        nick_empty = 1'b0;

        // Timeout with no ack.
        ack_delay = 0;
        run_txn(5, 1'b0, 1'b0);
        check("to_nickels", n_nick, 1);
        check("to_err", n_err, 1);
        check("to_err_delay", last_err_cyc - first_pulse_cyc, TIMEOUT + 1);
        check("to_owed", 32'(owed), 32'(5));

        // Ack on the last WAIT_ACK cycle wins over the timeout.
        ack_delay = TIMEOUT;
        run_txn(5, 1'b0, 1'b0);
        check("late_ack_done", n_done, 1);
        check("late_ack_err", n_err, 0);
        check("late_ack_delay", last_done_cyc - first_pulse_cyc, TIMEOUT + 1);

        // One cycle too late.
        ack_delay = TIMEOUT + 1;
        run_txn(5, 1'b0, 1'b0);
        check("too_late_err", n_err, 1);
        check("too_late_done", n_done, 0);

        // Zero amount.
        ack_delay = 1;
        run_txn(0, 1'b0, 1'b0);
        check("zero_done_latency", last_done_cyc - t0, 1);
        check("zero_pulses", n_dime + n_nick, 0);

        // start held high while busy is ignored.
        run_txn(10, 1'b1, 1'b0);
        check("hold_dimes", n_dime, 1);
        check("hold_done", n_done, 1);
        check("hold_err", n_err, 0);

        // Largest legal amount.
        run_txn(255, 1'b0, 1'b0);
        check("a255_dimes", n_dime, 25);
        check("a255_nickels", n_nick, 1);
        check("a255_done", n_done, 1);

        // Reset during WAIT_ACK aborts silently, then a fresh request works.
        ack_delay = 0;
        clear_obs();
        start  = 1'b1;
        amount = AMT_W'(10);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort", 32'({dime_out, nick_out, busy, done, err, owed}), 32'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_end_pulse", n_done + n_err, 0);
        check("rst_one_dime", n_dime, 1);
        ack_delay = 1;
        run_txn(5, 1'b0, 1'b0);
        check("post_rst_nickel", n_nick, 1);
        check("post_rst_dime", n_dime, 0);
        check("post_rst_done", n_done, 1);

        // Randomized traffic; the compare process checks every cycle.
        noise = 1'b1;
        for (int i = 0; i < 150; i++) begin
            dime_empty = ($urandom_range(0, 3) == 0);
            nick_empty = ($urandom_range(0, 5) == 0);
            ack_delay  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT + 2))
                                                      : int'($urandom_range(1, 3));
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 51)) * 5;
            start  = 1'b1;
            amount = AMT_W'(amt);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                start  = ($urandom_range(0, 3) == 0);
                amount = AMT_W'($urandom);
                if ($urandom_range(0, 19) == 0) dime_empty = ~dime_empty;
                if ($urandom_range(0, 19) == 0) nick_empty = ~nick_empty;
                rst = ($urandom_range(0, 399) == 0);
            end while (busy === 1'b1 && n < 3000);
            if (busy !== 1'b0) check("rand_budget", 32'(busy), 32'(0));
            rst   = 1'b0;
            start = 1'b0;
            @(negedge clk);
        end
        noise = 1'b0;
        repeat (TIMEOUT + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
